random_pulse_array: RTL and testbench

RANDOM_PULSE_ARRAY -- requirements
Module: random_pulse_array

---
 rtl/random_pulse_array_if.sv | 26 ++
 rtl/random_pulse_array.sv | 125 ++++++++++++
 tb/tb_random_pulse_array.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/random_pulse_array_if.sv
// Control and status bundle for random_pulse_array: trigger controls in, pulses and stats out.
interface random_pulse_array_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4
);
  logic                en;
  logic                seed_load;
  logic [15:0]         seed;
  logic [7:0]          density;
  logic [CNT_W-1:0]    pulse_len;
  logic [CNT_W-1:0]    min_gap;
  logic [CHANNELS-1:0] force_trig;
  logic [CHANNELS-1:0] pulse;
  logic                busy;
  logic [15:0]         pulse_count;

  modport master (
    output en, seed_load, seed, density, pulse_len, min_gap, force_trig,
    input  pulse, busy, pulse_count
  );

  modport slave (
    input  en, seed_load, seed, density, pulse_len, min_gap, force_trig,
    output pulse, busy, pulse_count
  );
endinterface

// File: rtl/random_pulse_array.sv
// Array of LFSR-driven pulse generators, each an IDLE/PULSE/GAP channel with latched timing,
// plus a saturating count of pulses started.
module random_pulse_array #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  random_pulse_array_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [15:0]         lfsr_q  [CHANNELS];
  logic [15:0]         lfsr_d  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CNT_W-1:0]    gap_q   [CHANNELS];
  logic [CNT_W-1:0]    gap_d   [CHANNELS];
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic [15:0]         count_q, count_d;
  logic [16:0]         count_sum;
  // Low for the first edge after reset release so no trigger lands in that cycle.
  logic                armed_q;

  function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned k);
    logic [31:0] prod;
    logic [15:0] s;
    prod = 32'h1F35 * (k + 1);
    s    = base ^ prod[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always_comb begin
    busy_d    = 1'b0;
    trig      = '0;
    pulse_d   = '0;
    count_sum = {1'b0, count_q};
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      gap_d[c]   = gap_q[c];
      lfsr_d[c]  = lfsr_q[c];
      if (bus.seed_load) begin
        lfsr_d[c]  = chan_seed(bus.seed, c);
        state_d[c] = StIdle;
        cnt_d[c]   = '0;
      end else begin
        if (bus.en) lfsr_d[c] = lfsr_step(lfsr_q[c]);
        case (state_q[c])
          StIdle: begin
            trig[c] = armed_q &&
                      ((bus.en && (lfsr_q[c][7:0] < bus.density)) || bus.force_trig[c]);
            if (trig[c]) begin
              state_d[c] = StPulse;
              // cnt holds remaining cycles after the current one; length 0 behaves as 1.
              cnt_d[c]   = (bus.pulse_len == '0) ? '0 : bus.pulse_len - CNT_W'(1);
              gap_d[c]   = bus.min_gap;
            end
          end
          StPulse: begin
            if (cnt_q[c] != '0) begin
              cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end else if (gap_q[c] != '0) begin
              state_d[c] = StGap;
              cnt_d[c]   = gap_q[c] - CNT_W'(1);
            end else begin
              state_d[c] = StIdle;
            end
          end
          StGap: begin
            if (cnt_q[c] != '0) cnt_d[c] = cnt_q[c] - CNT_W'(1);
            else                state_d[c] = StIdle;
          end
          default: state_d[c] = StIdle;
        endcase
      end
      pulse_d[c] = (state_d[c] == StPulse);
      busy_d     = busy_d | (state_d[c] != StIdle);
      count_sum  = count_sum + 17'(trig[c]);
    end
    if (bus.seed_load)    count_d = '0;
    else if (count_sum[16]) count_d = 16'hFFFF;
    else                  count_d = count_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= StIdle;
        lfsr_q[c]  <= chan_seed(16'hACE1, c);
        cnt_q[c]   <= '0;
        gap_q[c]   <= '0;
      end
      pulse_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        lfsr_q[c]  <= lfsr_d[c];
        cnt_q[c]   <= cnt_d[c];
        gap_q[c]   <= gap_d[c];
      end
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      armed_q <= 1'b1;
    end
  end

  assign bus.pulse       = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.pulse_count = count_q;

endmodule

// File: tb/tb_random_pulse_array.sv
// Self-checking bench: per-cycle comparison against a remaining-cycles model of each channel,
// directed scenarios with hand-computed expectations, randomized traffic and saturation.
module tb_random_pulse_array;
  localparam int NCH = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   check_on = 0;

  random_pulse_array_if #(.CHANNELS(NCH), .CNT_W(4)) bus ();

  random_pulse_array #(.CHANNELS(NCH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is "cycles of high left" then "cycles of gap left".
  int m_lfsr [NCH];
  int m_high [NCH];
  int m_low  [NCH];
  int m_gapl [NCH];
  int m_count;
  bit m_armed;

  function automatic int m_seed(input int base, input int k);
    int v;
    v = (base ^ ((32'h1F35 * (k + 1)) % 65536)) % 65536;
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int m_step(input int v);
    int fb;
    fb = $countones(v & 32'hB400) % 2;
    return ((v * 2) + fb) % 65536;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lfsr[c] = m_seed(32'hACE1, c);
      m_high[c] = 0;
      m_low[c]  = 0;
      m_gapl[c] = 0;
    end
    m_count = 0;
    m_armed = 0;
  endtask

  task automatic model_step();
    int ntrig;
    if (bus.seed_load) begin
      for (int c = 0; c < NCH; c++) begin
        m_lfsr[c] = m_seed(int'(bus.seed), c);
        m_high[c] = 0;
        m_low[c]  = 0;
      end
      m_count = 0;
      m_armed = 1;
      return;
    end
    ntrig = 0;
    for (int c = 0; c < NCH; c++) begin
      if (m_high[c] > 0) begin
        m_high[c]--;
        if (m_high[c] == 0) m_low[c] = m_gapl[c];
      end else if (m_low[c] > 0) begin
        m_low[c]--;
      end else if (m_armed && ((bus.en && (m_lfsr[c] % 256) < int'(bus.density))
                               || bus.force_trig[c])) begin
        m_high[c] = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
        m_gapl[c] = int'(bus.min_gap);
        ntrig++;
      end
      if (bus.en) m_lfsr[c] = m_step(m_lfsr[c]);
    end
    m_count = (m_count + ntrig > 65535) ? 65535 : m_count + ntrig;
    m_armed = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    logic [NCH-1:0] exp_pulse;
    logic           exp_busy;
    forever begin
      @(negedge clk);
      if (check_on) begin
        exp_pulse = '0;
        exp_busy  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          exp_pulse[c] = (m_high[c] > 0);
          exp_busy     = exp_busy | (m_high[c] > 0) | (m_low[c] > 0);
        end
        chk("model_pulse", 32'(bus.pulse), 32'(exp_pulse));
        chk("model_busy", 32'(bus.busy), 32'(exp_busy));
        chk("model_count", 32'(bus.pulse_count), 32'(m_count));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [NCH-1:0] trace [2][1000];
  int             fires [NCH];
  int             diffs;
  int             n;
  logic [15:0]    seed_pool [4] = '{16'h1F35, 16'h3E6A, 16'h5A5A, 16'hACE1};

  initial begin
    rst_n          = 0;
    bus.en         = 0;
    bus.seed_load  = 0;
    bus.seed       = 16'h0;
    bus.density    = 8'd0;
    bus.pulse_len  = 4'd0;
    bus.min_gap    = 4'd0;
    bus.force_trig = '0;

    // Pin the model's seeding and LFSR step to hand-computed values.
    chk("model_seed_ch0", 32'(m_seed(32'hACE1, 0)), 32'hB3D4);
    chk("model_seed_zero", 32'(m_seed(32'h1F35, 0)), 32'h0001);
    chk("model_lfsr_step", 32'(m_step(32'h8000)), 32'h0001);

    repeat (3) tick();
    rst_n    = 1;
    check_on = 1;

    // Disabled with max density: nothing may happen.
    bus.density = 8'd255;
    repeat (20) tick();
    chk("idle_pulse", 32'(bus.pulse), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_count", 32'(bus.pulse_count), 0);

    // Forced single pulse: len 3, gap 2, with en low.
    bus.pulse_len  = 4'd3;
    bus.min_gap    = 4'd2;
    bus.force_trig = 4'b0001;
    tick();
    bus.force_trig = '0;
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("force_pulse_c%0d", i), 32'(bus.pulse[0]), 32'(i <= 3));
      chk($sformatf("force_busy_c%0d", i), 32'(bus.busy), 32'(i <= 5));
      tick();
    end
    chk("force_count", 32'(bus.pulse_count), 1);

    // All channels together, then repeated force while busy is ignored.
    bus.pulse_len  = 4'd4;
    bus.min_gap    = 4'd3;
    bus.force_trig = 4'b1111;
    tick();
    chk("all_pulse", 32'(bus.pulse), 32'hF);
    chk("all_count", 32'(bus.pulse_count), 5);
    repeat (5) tick();
    bus.force_trig = '0;
    chk("ignored_count", 32'(bus.pulse_count), 5);
    repeat (4) tick();

    // seed_load mid-pulse aborts everything.
    bus.pulse_len  = 4'd15;
    bus.min_gap    = 4'd5;
    bus.force_trig = 4'b0001;
    tick();
    bus.force_trig = '0;
    repeat (3) tick();
    bus.seed_load = 1;
    tick();
    bus.seed_load = 0;
    chk("abort_pulse", 32'(bus.pulse), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_count", 32'(bus.pulse_count), 0);

    // Asynchronous reset in the middle of a gap.
    bus.pulse_len  = 4'd1;
    bus.min_gap    = 4'd10;
    bus.force_trig = 4'b0010;
    tick();
    bus.force_trig = '0;
    repeat (2) tick();
    chk("gap_busy_before_rst", 32'(bus.busy), 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_count", 32'(bus.pulse_count), 0);
    chk("async_rst_pulse", 32'(bus.pulse), 0);
    tick();
    rst_n = 1;
    tick();

    // Repeatability with a fixed seed, density 64.
    bus.seed      = 16'h5A5A;
    bus.density   = 8'd64;
    bus.pulse_len = 4'd1;
    bus.min_gap   = 4'd0;
    bus.en        = 1;
    for (int r = 0; r < 2; r++) begin
      bus.seed_load = 1;
      tick();
      bus.seed_load = 0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        trace[r][i] = bus.pulse;
      end
    end
    diffs = 0;
    for (int c = 0; c < NCH; c++) fires[c] = 0;
    for (int i = 0; i < 1000; i++) begin
      if (trace[0][i] !== trace[1][i]) diffs++;
      for (int c = 0; c < NCH; c++) fires[c] += int'(trace[0][i][c]);
    end
    chk("repeat_trace_diffs", 32'(diffs), 0);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("rate_ch%0d_in_range", c), 32'(fires[c] >= 100 && fires[c] <= 350), 1);
    diffs = 0;
    for (int i = 0; i < 1000; i++) if (trace[0][i][0] !== trace[0][i][1]) diffs++;
    chk("channels_differ", 32'(diffs > 0), 1);

    // Randomized traffic, including zero-seed reloads and mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      bus.en         = ($urandom_range(0, 3) != 0);
      bus.seed_load  = ($urandom_range(0, 63) == 0);
      bus.seed       = ($urandom_range(0, 1) == 0) ? seed_pool[$urandom_range(0, 3)]
                                                   : 16'($urandom);
      bus.density    = 8'($urandom);
      bus.pulse_len  = 4'($urandom);
      bus.min_gap    = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      bus.force_trig = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      tick();
    end

    // Saturation: dense short pulses until the counter pins at FFFF.
    bus.en         = 1;
    bus.density    = 8'd255;
    bus.pulse_len  = 4'd1;
    bus.min_gap    = 4'd0;
    bus.force_trig = '0;
    bus.seed_load  = 1;
    tick();
    bus.seed_load = 0;
    n = 0;
    while (bus.pulse_count !== 16'hFFFF && n < 40000) begin
      tick();
      n++;
    end
    chk("sat_reached", 32'(n < 40000), 1);
    repeat (50) tick();
    chk("sat_held", 32'(bus.pulse_count), 32'hFFFF);

    check_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
